// File: rtl/axis_i2c_pkg.sv
// rtl/axis_i2c_pkg.sv - shared constants and types for the AXI-Stream I2C master datapath
//
// Purpose : width/depth defaults and the receive FIFO entry layout used by the
//           I2C read-side packer and its FIFO.
// Contents: I2C_DATA_WIDTH, RX_FIFO_DEPTH, RX_PKT_LEN, rx_entry_t.
package axis_i2c_pkg;

  localparam int I2C_DATA_WIDTH = 8;
  localparam int RX_FIFO_DEPTH  = 16;
  localparam int RX_PKT_LEN     = 4;

  typedef struct packed {
    logic                      last;
    logic [I2C_DATA_WIDTH-1:0] data;
  } rx_entry_t;

endpackage

// File: rtl/axis_if.sv
// rtl/axis_if.sv - minimal AXI-Stream data/handshake bundle
//
// Purpose : carries tdata/tvalid/tready between a stream master and slave.
// Signals : tdata [DATA_WIDTH], tvalid (master->slave), tready (slave->master).
interface axis_if #(
  parameter int DATA_WIDTH = 8
);

  logic [DATA_WIDTH-1:0] tdata;
  logic                  tvalid;
  logic                  tready;

  modport master (output tdata, output tvalid, input tready);
  modport slave  (input tdata, input tvalid, output tready);

endinterface

// File: rtl/axis_i2c_sync_fifo.sv
// rtl/axis_i2c_sync_fifo.sv - single-clock FIFO with combinational head read
//
// Purpose : small synchronous FIFO; a push while full is accepted only when a
//           pop happens in the same cycle.
// Ports   : clk, rst (sync, active-high), clear (sync flush),
//           push/push_data, pop, head (zero when empty), full, empty,
//           level (0..DEPTH).
module axis_i2c_sync_fifo #(
  parameter int WIDTH = 9,
  parameter int DEPTH = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   clear,
  input  logic                   push,
  input  logic [WIDTH-1:0]       push_data,
  input  logic                   pop,
  output logic [WIDTH-1:0]       head,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] level
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             push_ok;
  logic             pop_ok;

  assign full    = (level == LVL_W'(DEPTH));
  assign empty   = (level == '0);
  assign pop_ok  = pop && !empty;
  // A full FIFO can still take a byte if the head leaves in the same cycle.
  assign push_ok = push && (!full || pop_ok);

  // Head is forced to zero when empty so stale storage never shows on the bus.
  assign head = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push_ok && !rst && !clear) begin
      mem[wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push_ok, pop_ok})
        2'b10:   level <= level + LVL_W'(1);
        2'b01:   level <= level - LVL_W'(1);
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/axis_i2c_rx_packer.sv
// rtl/axis_i2c_rx_packer.sv - packs I2C read bytes into an AXI-Stream packet stream
//
// Purpose : captures one byte per rising edge of rvalid_i, tags packet ends
//           (every PKT_LEN bytes or on eop_i), buffers them in a FIFO and
//           presents the FIFO head as an AXI-Stream master.
// Ports   : clk_i, rst_i (sync, active-high), i2c_rdata_i, rvalid_i, eop_i,
//           flush_i (sync clear), m_axis (tdata/tvalid out, tready in),
//           m_axis_tlast_o, level_o (0..DEPTH), overflow_o (sticky drop flag).
module axis_i2c_rx_packer
  import axis_i2c_pkg::*;
#(
  parameter int DATA_WIDTH = I2C_DATA_WIDTH,
  parameter int DEPTH      = RX_FIFO_DEPTH,
  parameter int PKT_LEN    = RX_PKT_LEN
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic [DATA_WIDTH-1:0]  i2c_rdata_i,
  input  logic                   rvalid_i,
  input  logic                   eop_i,
  input  logic                   flush_i,
  axis_if.master                 m_axis,
  output logic                   m_axis_tlast_o,
  output logic [$clog2(DEPTH):0] level_o,
  output logic                   overflow_o
);

  localparam int CNT_W = (PKT_LEN > 1) ? $clog2(PKT_LEN) : 1;
  localparam int ENT_W = DATA_WIDTH + 1;

  logic             rvalid_q;
  logic             capture;
  logic             last_tag;
  logic             pop;
  logic             full;
  logic             empty;
  logic             accepted;
  logic [CNT_W-1:0] pkt_cnt;
  logic [ENT_W-1:0] head;

  // rvalid_i may stay high for several cycles; only its rising edge is a byte.
  assign capture  = rvalid_i && !rvalid_q;
  assign last_tag = eop_i || (pkt_cnt == CNT_W'(PKT_LEN - 1));
  assign pop      = m_axis.tvalid && m_axis.tready;
  // Mirrors the FIFO's own acceptance rule so pkt_cnt only advances on bytes kept.
  assign accepted = capture && !flush_i && (!full || pop);

  axis_i2c_sync_fifo #(
    .WIDTH (ENT_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk_i),
    .rst       (rst_i),
    .clear     (flush_i),
    .push      (capture && !flush_i),
    .push_data ({last_tag, i2c_rdata_i}),
    .pop       (pop),
    .head      (head),
    .full      (full),
    .empty     (empty),
    .level     (level_o)
  );

  assign m_axis.tvalid  = !empty;
  assign m_axis.tdata   = head[DATA_WIDTH-1:0];
  assign m_axis_tlast_o = head[DATA_WIDTH];

  // Flush deliberately leaves the edge history alone so a held rvalid_i
  // is not recaptured after the clear.
  always_ff @(posedge clk_i) begin
    if (rst_i) rvalid_q <= 1'b0;
    else       rvalid_q <= rvalid_i;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) begin
      pkt_cnt <= '0;
    end else if (accepted) begin
      pkt_cnt <= last_tag ? '0 : pkt_cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) begin
      overflow_o <= 1'b0;
    end else if (capture && full && !pop) begin
      overflow_o <= 1'b1;
    end
  end

endmodule

// File: tb/tb_axis_i2c_rx_packer.sv
// tb/tb_axis_i2c_rx_packer.sv - self-checking bench for axis_i2c_rx_packer
module tb_axis_i2c_rx_packer;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] rdata;
  logic       rvalid;
  logic       eop;
  logic       flush;
  logic       tlast;
  logic [4:0] level;
  logic       overflow;

  int checks   = 0;
  int failures = 0;

  logic [8:0] exp_q[$];

  axis_if #(.DATA_WIDTH(8)) axis_bus ();

  axis_i2c_rx_packer #(
    .DATA_WIDTH (8),
    .DEPTH      (16),
    .PKT_LEN    (4)
  ) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .i2c_rdata_i    (rdata),
    .rvalid_i       (rvalid),
    .eop_i          (eop),
    .flush_i        (flush),
    .m_axis         (axis_bus),
    .m_axis_tlast_o (tlast),
    .level_o        (level),
    .overflow_o     (overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard consumer: any beat accepted at the next edge is compared
  // against the oldest expected entry.
  always @(negedge clk) begin
    if (!rst && !flush && axis_bus.tvalid === 1'b1 && axis_bus.tready === 1'b1) begin
      chk("beat_pending", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        logic [8:0] e;
        e = exp_q.pop_front();
        chk("beat_data", 32'(axis_bus.tdata), 32'(e[7:0]));
        chk("beat_last", 32'(tlast), 32'(e[8]));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One-cycle rvalid pulse followed by one idle cycle.
  task automatic pulse(input logic [7:0] d, input logic e, input logic exp_last, input logic keep);
    rdata  = d;
    rvalid = 1'b1;
    eop    = e;
    if (keep) exp_q.push_back({exp_last, d});
    step();
    rvalid = 1'b0;
    eop    = 1'b0;
    step();
  endtask

  task automatic do_flush();
    flush = 1'b1;
    step();
    flush = 1'b0;
  endtask

  task automatic wait_drained(input string tag);
    int n = 0;
    while (level !== 5'd0 && n < 200) begin
      step();
      n++;
    end
    step();
    chk(tag, 32'(level), 32'd0);
    chk({tag, "_sb"}, 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    int peak;
    rst    = 1'b1;
    rdata  = 8'h00;
    rvalid = 1'b0;
    eop    = 1'b0;
    flush  = 1'b0;
    axis_bus.tready = 1'b1;
    step();
    step();
    chk("rst_tvalid",   32'(axis_bus.tvalid), 32'd0);
    chk("rst_tlast",    32'(tlast),           32'd0);
    chk("rst_tdata",    32'(axis_bus.tdata),  32'd0);
    chk("rst_level",    32'(level),           32'd0);
    chk("rst_overflow", 32'(overflow),        32'd0);
    rst = 1'b0;
    step();

    // 1: four bytes, packet end on the fourth
    pulse(8'h11, 1'b0, 1'b0, 1'b1);
    pulse(8'h22, 1'b0, 1'b0, 1'b1);
    pulse(8'h33, 1'b0, 1'b0, 1'b1);
    pulse(8'h44, 1'b0, 1'b1, 1'b1);
    wait_drained("t1_level");

    // 2: rvalid held for five cycles is one byte
    peak   = 0;
    rdata  = 8'hA5;
    rvalid = 1'b1;
    exp_q.push_back({1'b0, 8'hA5});
    for (int i = 0; i < 5; i++) begin
      step();
      if (int'(level) > peak) peak = int'(level);
    end
    rvalid = 1'b0;
    step();
    chk("t2_peak", 32'(peak), 32'd1);
    wait_drained("t2_level");
    do_flush();
    step();

    // 3: fill with tready low, seventeenth byte lost
    axis_bus.tready = 1'b0;
    for (int i = 0; i < 17; i++) begin
      pulse(8'(i), 1'b0, (i % 4) == 3, i < 16);
    end
    chk("t3_level_full", 32'(level),    32'd16);
    chk("t3_overflow",   32'(overflow), 32'd1);
    chk("t3_head",       32'(axis_bus.tdata), 32'd0);
    axis_bus.tready = 1'b1;
    wait_drained("t3_level");
    chk("t3_overflow_sticky", 32'(overflow), 32'd1);
    do_flush();
    step();
    chk("flush_overflow", 32'(overflow), 32'd0);

    // 4: full FIFO, pop and push in the same cycle
    axis_bus.tready = 1'b0;
    for (int i = 0; i < 16; i++) begin
      pulse(8'(8'h80 + i), 1'b0, (i % 4) == 3, 1'b1);
    end
    chk("t4_level_full", 32'(level), 32'd16);
    rdata  = 8'h5A;
    rvalid = 1'b1;
    axis_bus.tready = 1'b1;
    exp_q.push_back({1'b0, 8'h5A});
    step();
    rvalid = 1'b0;
    chk("t4_level_same", 32'(level),    32'd16);
    chk("t4_overflow",   32'(overflow), 32'd0);
    wait_drained("t4_level");
    do_flush();
    step();

    // 5: eop tag restarts the packet count
    pulse(8'h01, 1'b0, 1'b0, 1'b1);
    pulse(8'h02, 1'b1, 1'b1, 1'b1);
    pulse(8'h03, 1'b0, 1'b0, 1'b1);
    pulse(8'h04, 1'b0, 1'b0, 1'b1);
    pulse(8'h05, 1'b0, 1'b0, 1'b1);
    pulse(8'h06, 1'b0, 1'b1, 1'b1);
    wait_drained("t5_level");

    // 6: flush with a simultaneous capture discards everything
    axis_bus.tready = 1'b0;
    pulse(8'h61, 1'b0, 1'b0, 1'b1);
    pulse(8'h62, 1'b0, 1'b0, 1'b1);
    pulse(8'h63, 1'b0, 1'b0, 1'b1);
    chk("t6_level_pre", 32'(level), 32'd3);
    rdata  = 8'h77;
    rvalid = 1'b1;
    flush  = 1'b1;
    step();
    exp_q.delete();
    flush  = 1'b0;
    rvalid = 1'b0;
    chk("t6_tvalid",   32'(axis_bus.tvalid), 32'd0);
    chk("t6_level",    32'(level),           32'd0);
    chk("t6_overflow", 32'(overflow),        32'd0);
    axis_bus.tready = 1'b1;
    repeat (4) step();
    chk("t6_level_post", 32'(level), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
